// File: rtl/uart_pkg.sv
// Shared definitions for the parametrised UART receiver: parity modes, FSM
// state enumeration and the parity helper used when checking a frame.
package uart_pkg;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_EVEN = 1;
    localparam int PARITY_ODD  = 2;

    localparam int MAX_DATA_BITS = 9;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        PARITY    = 3'd3,
        STOP      = 3'd4,
        WAIT_IDLE = 3'd5
    } rx_state_t;

    // Returns the parity bit a correct sender would transmit for this word.
    function automatic logic parity_calc(input logic [MAX_DATA_BITS-1:0] data,
                                         input int mode);
        logic p;
        p = 1'b0;
        case (mode)
            PARITY_EVEN: p = ^data;
            PARITY_ODD:  p = ~(^data);
            default:     p = 1'b0;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/uart_rx_param_if.sv
// Receiver-side bundle: serial line in, held word out through a valid/ready
// register, plus the error indications.
interface uart_rx_param_if #(
    parameter int DATA_BITS = 7
);
    logic                 rx_in;
    logic                 rx_ready;
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 rx_parity_err;
    logic                 framing_err;
    logic                 overrun_err;

    modport master (
        input  rx_in,
        input  rx_ready,
        output rx_data,
        output rx_valid,
        output rx_parity_err,
        output framing_err,
        output overrun_err
    );

    modport slave (
        output rx_in,
        output rx_ready,
        input  rx_data,
        input  rx_valid,
        input  rx_parity_err,
        input  framing_err,
        input  overrun_err
    );
endinterface

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the asynchronous serial line, idle-high on reset,
// with a one-cycle pulse on each synchronised falling edge.
module uart_rx_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic line,
    output logic fall
);

    logic meta;
    logic prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b1;
            line <= 1'b1;
            prev <= 1'b1;
        end else begin
            meta <= async_in;
            line <= meta;
            prev <= line;
        end
    end

    assign fall = prev & ~line;

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised oversampling UART receiver: glitch-filtered start detection,
// optional parity, 1 or 2 stop bits, one-entry valid/ready output holding register.
module uart_rx_param
    import uart_pkg::*;
#(
    parameter int DATA_BITS    = 7,
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY_MODE  = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    uart_rx_param_if.master  bus
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int IW = $clog2(DATA_BITS + 1);

    localparam logic [CW-1:0] HALF_LOAD = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_LOAD = CW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] LAST_IDX  = IW'(DATA_BITS - 1);
    localparam logic [1:0]    LAST_STOP = 2'(STOP_BITS - 1);
    localparam bit            HAS_PARITY = (PARITY_MODE != PARITY_NONE);

    localparam logic [2:0] ST_IDLE      = IDLE;
    localparam logic [2:0] ST_START     = START;
    localparam logic [2:0] ST_DATA      = DATA;
    localparam logic [2:0] ST_PARITY    = PARITY;
    localparam logic [2:0] ST_STOP      = STOP;
    localparam logic [2:0] ST_WAIT_IDLE = WAIT_IDLE;

    logic                 line;
    logic                 fall;
    logic [2:0]           state;
    logic [CW-1:0]        cnt;
    logic [IW-1:0]        bit_idx;
    logic [1:0]           stop_idx;
    logic [DATA_BITS-1:0] shreg;
    logic                 par_err;
    logic                 deliver;
    logic                 framing_q;
    logic                 overrun_q;
    logic [DATA_BITS-1:0] data_q;
    logic                 valid_q;
    logic                 perr_q;
    logic                 expire;

    uart_rx_sync u_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .async_in (bus.rx_in),
        .line     (line),
        .fall     (fall)
    );

    assign expire = (cnt == '0);

    // Frame sequencer; every sample is taken when the bit-period counter hits zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            stop_idx  <= '0;
            shreg     <= '0;
            par_err   <= 1'b0;
            deliver   <= 1'b0;
            framing_q <= 1'b0;
        end else begin
            deliver   <= 1'b0;
            framing_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (fall) begin
                        state <= ST_START;
                        cnt   <= HALF_LOAD;
                    end
                end
                ST_START: begin
                    if (expire) begin
                        if (!line) begin
                            state   <= ST_DATA;
                            cnt     <= FULL_LOAD;
                            bit_idx <= '0;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_DATA: begin
                    if (expire) begin
                        shreg <= {line, shreg[DATA_BITS-1:1]};
                        cnt   <= FULL_LOAD;
                        if (bit_idx == LAST_IDX) begin
                            bit_idx  <= '0;
                            stop_idx <= '0;
                            par_err  <= 1'b0;
                            state    <= HAS_PARITY ? ST_PARITY : ST_STOP;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_PARITY: begin
                    if (expire) begin
                        par_err  <= line ^ parity_calc(MAX_DATA_BITS'(shreg), PARITY_MODE);
                        cnt      <= FULL_LOAD;
                        stop_idx <= '0;
                        state    <= ST_STOP;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_STOP: begin
                    if (expire) begin
                        cnt <= FULL_LOAD;
                        if (!line) begin
                            framing_q <= 1'b1;
                            state     <= ST_WAIT_IDLE;
                        end else if (stop_idx == LAST_STOP) begin
                            deliver <= 1'b1;
                            state   <= ST_IDLE;
                        end else begin
                            stop_idx <= stop_idx + 1'b1;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_WAIT_IDLE: begin
                    // A held-low line (break) must return high before a new start is armed.
                    if (line) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Holding register: a same-cycle accept and load keeps valid high without overrun.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q    <= '0;
            valid_q   <= 1'b0;
            perr_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            overrun_q <= 1'b0;
            if (deliver) begin
                if (!valid_q || bus.rx_ready) begin
                    data_q  <= shreg;
                    perr_q  <= par_err;
                    valid_q <= 1'b1;
                end else begin
                    overrun_q <= 1'b1;
                end
            end else if (valid_q && bus.rx_ready) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign bus.rx_data       = data_q;
    assign bus.rx_valid      = valid_q;
    assign bus.rx_parity_err = perr_q;
    assign bus.framing_err   = framing_q;
    assign bus.overrun_err   = overrun_q;

endmodule

// File: doc/uart_rx_param.md
Name: uart_rx_param

Overview:
- Parametrised successor to the 7-bit fixed-format UART receiver.
- Generalised in data width, parity mode and stop-bit count; oversamples the line, rejects start-bit glitches and reports parity, framing and overrun errors.
- Delivers each word through a one-entry valid/ready holding register.
- Sits between the serial line driven by the sender and the consuming logic, in the receiver clock domain.

Parameters:
DATA_BITS, 7, data bits per frame, legal 5..9, LSB first
CLKS_PER_BIT, 16, clk cycles per serial bit, legal >= 4, even
PARITY_MODE, 0, 0 = none, 1 = even, 2 = odd
STOP_BITS, 1, stop bits checked, legal 1 or 2

Ports:
clk  input  1  receiver clock
rst_n  input  1  asynchronous active-low reset
rx_in  input  1  serial line, idle high, asynchronous to clk
rx_ready  input  1  consumer accepts the held word
rx_data  output  DATA_BITS  received word, stable while rx_valid=1
rx_valid  output  1  word held, waiting for consumer
rx_parity_err  output  1  parity mismatch for the held word, qualified by rx_valid
framing_err  output  1  one-cycle pulse: stop bit sampled low
overrun_err  output  1  one-cycle pulse: frame completed while a word was still held

Behaviour:
- Reset (rst_n=0, async): rx_data=0, rx_valid=0, rx_parity_err=0, framing_err=0, overrun_err=0, FSM=IDLE, counters=0, synchroniser flops=1.
- rx_in passes through a 2-FF synchroniser (2 cycles latency); all sampling uses the synchronised value.
- Bit counter width: $clog2(CLKS_PER_BIT). Data index width: $clog2(DATA_BITS+1).
- FSM states: IDLE, START, DATA, PARITY, STOP, WAIT_IDLE.
- IDLE: on synchronised 1->0 edge, go to START and load the counter with CLKS_PER_BIT/2-1.
- START: at counter expiry, sample the line.
  - Low: go to DATA and reload the counter with CLKS_PER_BIT-1.
  - High: glitch; return to IDLE with no outputs.
- DATA: sample at each expiry and shift into the shift register, LSB first. After DATA_BITS samples, go to PARITY if PARITY_MODE!=0, else STOP.
- PARITY: one sample.
  - Error condition, even mode: XOR of data bits and parity bit = 1.
  - Error condition, odd mode: that XOR = 0.
- STOP: STOP_BITS samples, one per bit period.
  - Any stop sample low: pulse framing_err for one cycle, discard the word, go to WAIT_IDLE.
  - All stop samples high: attempt delivery on the cycle after the final stop sample, then go to IDLE.
- WAIT_IDLE: stay until the synchronised line is high, then go to IDLE. Break conditions cannot generate false frames.
- Delivery, rx_valid=0: load rx_data and rx_parity_err, set rx_valid=1.
- Delivery, rx_valid=1 and rx_ready=0 in the same cycle: pulse overrun_err, keep the old word, drop the new one.
- Delivery, rx_valid=1 and rx_ready=1 in the same cycle: accept the old word and load the new one; rx_valid stays 1 and no overrun.
- Handshake: rx_valid clears on the cycle after rx_valid and rx_ready are both high, unless a same-cycle load occurs. rx_ready has no effect while rx_valid=0.
- Latency: rx_valid rises 1 cycle after the mid-point of the last stop bit.
- Receiving into the shift register continues while a word is held; only delivery can overrun.
- Reset mid-frame: immediate return to the reset state. The partial frame is lost; the next full frame after the line returns idle is received normally.

Decomposition:
- Package uart_pkg holds:
  - PARITY_NONE/EVEN/ODD constants.
  - the rx_state_t enum (IDLE..WAIT_IDLE).
  - a function parity_calc(data, mode).
- One sub-module, uart_rx_sync: 2-FF synchroniser with reset-to-1 and falling-edge detect output. Instantiated once.

Test Plan:
- DATA_BITS=7, CLKS_PER_BIT=16, no parity, 1 stop. Send 7'h55 -> rx_data=7'h55, rx_valid=1 one cycle after the mid-stop sample, all error outputs 0.
- PARITY_MODE=1 (even). Send 7'h03 with parity bit 1 -> rx_data=7'h03, rx_parity_err=1. Resend with parity bit 0 -> rx_parity_err=0.
- Send 7'h2A with the stop bit driven low, then hold the line low for 40 bit times -> exactly one framing_err pulse, rx_valid stays 0. After the line returns high, a frame with 7'h11 is received correctly.
- Drive rx_in low for 4 cycles in IDLE (shorter than CLKS_PER_BIT/2) -> no state beyond START, no outputs.
- rx_ready=0. Send 7'h01 then 7'h02 -> rx_data stays 7'h01, one overrun_err pulse at completion of the second frame. Raise rx_ready -> rx_valid falls next cycle.
- Assert rst_n=0 for 3 cycles during the DATA bit index 3 sample of a frame -> all outputs 0 immediately. Release and send 7'h7F -> rx_data=7'h7F.
